// File: rtl/inc_seq_checker.sv
// rtl/inc_seq_checker.sv - incrementing byte-stream sequence checker with lock/flywheel
// Tracks an expected +1 sequence, locks after a run of matches and flywheels through corrupt bytes.
module inc_seq_checker #(
    parameter int P_LOCK_CNT   = 4,
    parameter int P_UNLOCK_CNT = 3,
    parameter int P_ERR_W      = 16
) (
    input  logic               CLK_I,
    input  logic               RST_X,
    input  logic [7:0]         DATA_I,
    input  logic               VALID_I,
    input  logic               CLR_I,
    output logic               LOCKED_O,
    output logic               ERR_O,
    output logic [P_ERR_W-1:0] ERR_CNT_O,
    output logic [7:0]         EXP_DATA_O
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_SYNC = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    localparam logic [3:0]         LP_LOCK_LAST   = 4'(P_LOCK_CNT - 1);
    localparam logic [3:0]         LP_UNLOCK_LAST = 4'(P_UNLOCK_CNT - 1);
    localparam logic [P_ERR_W-1:0] LP_CNT_ONE     = {{(P_ERR_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    logic [3:0]         r_match_cnt;
    logic [3:0]         r_miss_cnt;
    logic [7:0]         r_exp;
    logic               r_err;
    logic               r_locked;
    logic [P_ERR_W-1:0] r_err_cnt;

    state_t             w_state;
    logic [3:0]         w_match_cnt;
    logic [3:0]         w_miss_cnt;
    logic [7:0]         w_exp;
    logic               w_err;
    logic [P_ERR_W-1:0] w_err_cnt;
    logic               w_match;

    assign w_match = (DATA_I == r_exp);

    always_comb begin
        w_state     = r_state;
        w_match_cnt = r_match_cnt;
        w_miss_cnt  = r_miss_cnt;
        w_exp       = r_exp;
        w_err       = 1'b0;
        case (r_state)
            ST_HUNT: begin
                if (VALID_I) begin
                    w_exp       = DATA_I + 8'd1;
                    w_match_cnt = 4'd0;
                    w_state     = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (VALID_I) begin
                    w_exp = DATA_I + 8'd1;
                    if (w_match) begin
                        w_match_cnt = r_match_cnt + 4'd1;
                        if (r_match_cnt == LP_LOCK_LAST) begin
                            w_state    = ST_LOCK;
                            w_miss_cnt = 4'd0;
                        end
                    end else begin
                        w_match_cnt = 4'd0;
                    end
                end
            end
            ST_LOCK: begin
                if (VALID_I) begin
                    if (w_match) begin
                        w_miss_cnt = 4'd0;
                        w_exp      = DATA_I + 8'd1;
                    end else begin
                        w_err = 1'b1;
                        // Corrupt byte is not trusted as a seed unless it is the one that drops lock
                        if (r_miss_cnt == LP_UNLOCK_LAST) begin
                            w_state     = ST_SYNC;
                            w_match_cnt = 4'd0;
                            w_miss_cnt  = 4'd0;
                            w_exp       = DATA_I + 8'd1;
                        end else begin
                            w_miss_cnt = r_miss_cnt + 4'd1;
                            w_exp      = r_exp + 8'd1;
                        end
                    end
                end
            end
            default: begin
                w_state     = ST_HUNT;
                w_match_cnt = 4'd0;
                w_miss_cnt  = 4'd0;
            end
        endcase
    end

    always_comb begin
        w_err_cnt = r_err_cnt;
        if (CLR_I) begin
            w_err_cnt = w_err ? LP_CNT_ONE : '0;
        end else if (w_err && (r_err_cnt != {P_ERR_W{1'b1}})) begin
            w_err_cnt = r_err_cnt + LP_CNT_ONE;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_X) begin
        if (!RST_X) begin
            r_state     <= ST_HUNT;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
            r_exp       <= 8'h00;
            r_err       <= 1'b0;
            r_locked    <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state;
            r_match_cnt <= w_match_cnt;
            r_miss_cnt  <= w_miss_cnt;
            r_exp       <= w_exp;
            r_err       <= w_err;
            r_locked    <= (w_state == ST_LOCK);
            r_err_cnt   <= w_err_cnt;
        end
    end

    assign LOCKED_O   = r_locked;
    assign ERR_O      = r_err;
    assign ERR_CNT_O  = r_err_cnt;
    assign EXP_DATA_O = r_exp;

endmodule

// File: tb/tb_inc_seq_checker.sv
// tb/tb_inc_seq_checker.sv - directed vector bench for inc_seq_checker
module tb_inc_seq_checker;

    typedef struct {
        logic        valid;
        logic [7:0]  data;
        logic        clr;
        logic        locked;
        logic        err;
        logic [15:0] cnt;
        logic [7:0]  expd;
    } vec_t;

    logic        CLK_I = 1'b0;
    logic        RST_X = 1'b0;
    logic [7:0]  DATA_I = 8'h00;
    logic        VALID_I = 1'b0;
    logic        CLR_I = 1'b0;
    logic        LOCKED_O;
    logic        ERR_O;
    logic [15:0] ERR_CNT_O;
    logic [7:0]  EXP_DATA_O;

    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_clr = 1'b0;
    logic        s_locked;
    logic        s_err;
    logic [1:0]  s_cnt;
    logic [7:0]  s_exp;

    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    inc_seq_checker dut (
        .CLK_I(CLK_I), .RST_X(RST_X), .DATA_I(DATA_I), .VALID_I(VALID_I), .CLR_I(CLR_I),
        .LOCKED_O(LOCKED_O), .ERR_O(ERR_O), .ERR_CNT_O(ERR_CNT_O), .EXP_DATA_O(EXP_DATA_O)
    );

    inc_seq_checker #(.P_ERR_W(2)) dut_sat (
        .CLK_I(CLK_I), .RST_X(RST_X), .DATA_I(s_data), .VALID_I(s_valid), .CLR_I(s_clr),
        .LOCKED_O(s_locked), .ERR_O(s_err), .ERR_CNT_O(s_cnt), .EXP_DATA_O(s_exp)
    );

    always #5 CLK_I = ~CLK_I;

    function automatic void add(input logic v, input logic [7:0] d, input logic c,
                                input logic l, input logic e, input logic [15:0] n,
                                input logic [7:0] x);
        vec_t t;
        t.valid = v; t.data = d; t.clr = c;
        t.locked = l; t.err = e; t.cnt = n; t.expd = x;
        vecs.push_back(t);
    endfunction

    task automatic check(input string name, input logic l, input logic e,
                         input logic [15:0] n, input logic [7:0] x);
        n_tests++;
        if (LOCKED_O !== l || ERR_O !== e || ERR_CNT_O !== n || EXP_DATA_O !== x) begin
            n_fail++;
            $display("FAIL %s: got locked=%0b err=%0b cnt=%0d exp=%02h, want locked=%0b err=%0b cnt=%0d exp=%02h",
                     name, LOCKED_O, ERR_O, ERR_CNT_O, EXP_DATA_O, l, e, n, x);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d, input logic c);
        VALID_I = v; DATA_I = d; CLR_I = c;
        @(posedge CLK_I);
        #1;
        VALID_I = 1'b0; CLR_I = 1'b0;
    endtask

    initial begin
        // Acquire lock on 10..14
        add(1, 8'h10, 0, 0, 0, 0, 8'h11);
        add(1, 8'h11, 0, 0, 0, 0, 8'h12);
        add(1, 8'h12, 0, 0, 0, 0, 8'h13);
        add(1, 8'h13, 0, 0, 0, 0, 8'h14);
        add(1, 8'h14, 0, 1, 0, 0, 8'h15);
        for (int d = 8'h15; d <= 8'h1F; d++) add(1, 8'(d), 0, 1, 0, 0, 8'(d + 1));
        // Single glitch
        add(1, 8'h20, 0, 1, 0, 0, 8'h21);
        add(1, 8'h55, 0, 1, 1, 1, 8'h22);
        add(1, 8'h22, 0, 1, 0, 1, 8'h23);
        add(1, 8'h23, 0, 1, 0, 1, 8'h24);
        for (int d = 8'h24; d <= 8'h2E; d++) add(1, 8'(d), 0, 1, 0, 1, 8'(d + 1));
        add(1, 8'h2F, 1, 1, 0, 0, 8'h30);
        // Loss of lock and re-acquire
        add(1, 8'h80, 0, 1, 1, 1, 8'h31);
        add(1, 8'h81, 0, 1, 1, 2, 8'h32);
        add(1, 8'h82, 0, 0, 1, 3, 8'h83);
        add(1, 8'h83, 0, 0, 0, 3, 8'h84);
        add(1, 8'h84, 0, 0, 0, 3, 8'h85);
        add(1, 8'h85, 0, 0, 0, 3, 8'h86);
        add(1, 8'h86, 0, 1, 0, 3, 8'h87);
        // Drop lock again, reseed near the wrap point
        add(1, 8'hE0, 0, 1, 1, 4, 8'h88);
        add(1, 8'hE1, 0, 1, 1, 5, 8'h89);
        add(1, 8'hF9, 0, 0, 1, 6, 8'hFA);
        add(1, 8'hFA, 0, 0, 0, 6, 8'hFB);
        add(1, 8'hFB, 0, 0, 0, 6, 8'hFC);
        add(1, 8'hFC, 0, 0, 0, 6, 8'hFD);
        add(1, 8'hFD, 0, 1, 0, 6, 8'hFE);
        // Wrap-around with gaps
        add(1, 8'hFE, 0, 1, 0, 6, 8'hFF);
        add(1, 8'hFF, 0, 1, 0, 6, 8'h00);
        add(0, 8'h77, 0, 1, 0, 6, 8'h00);
        add(0, 8'h33, 0, 1, 0, 6, 8'h00);
        add(0, 8'h00, 0, 1, 0, 6, 8'h00);
        add(1, 8'h00, 0, 1, 0, 6, 8'h01);
        add(1, 8'h01, 0, 1, 0, 6, 8'h02);
        // Clear alone, then build count to 5 with isolated glitches
        add(0, 8'h00, 1, 1, 0, 0, 8'h02);
        add(1, 8'h10, 0, 1, 1, 1, 8'h03);
        add(1, 8'h03, 0, 1, 0, 1, 8'h04);
        add(1, 8'h11, 0, 1, 1, 2, 8'h05);
        add(1, 8'h05, 0, 1, 0, 2, 8'h06);
        add(1, 8'h12, 0, 1, 1, 3, 8'h07);
        add(1, 8'h07, 0, 1, 0, 3, 8'h08);
        add(1, 8'h13, 0, 1, 1, 4, 8'h09);
        add(1, 8'h09, 0, 1, 0, 4, 8'h0A);
        add(1, 8'h14, 0, 1, 1, 5, 8'h0B);
        add(1, 8'h0B, 0, 1, 0, 5, 8'h0C);
        // Clear colliding with an error
        add(1, 8'h77, 1, 1, 1, 1, 8'h0D);
        add(1, 8'h0D, 0, 1, 0, 1, 8'h0E);

        repeat (3) @(posedge CLK_I);
        #1;
        check("reset_state", 0, 0, 0, 8'h00);
        @(negedge CLK_I);
        RST_X = 1'b1;
        @(posedge CLK_I);
        #1;

        foreach (vecs[i]) begin
            step(vecs[i].valid, vecs[i].data, vecs[i].clr);
            check($sformatf("vec%0d", i), vecs[i].locked, vecs[i].err, vecs[i].cnt, vecs[i].expd);
        end

        // Asynchronous reset while locked, checked before any clock edge
        #2;
        RST_X = 1'b0;
        #1;
        check("async_reset_mid_lock", 0, 0, 0, 8'h00);
        @(negedge CLK_I);
        RST_X = 1'b1;
        repeat (5) step(0, 8'h00, 0);
        check("idle_after_reset", 0, 0, 0, 8'h00);

        // Mismatch in SYNC reseeds silently
        step(1, 8'h40, 0); check("hunt_seed", 0, 0, 0, 8'h41);
        step(1, 8'h41, 0); check("sync_match", 0, 0, 0, 8'h42);
        step(1, 8'h99, 0); check("sync_reseed", 0, 0, 0, 8'h9A);
        step(1, 8'h9A, 0);
        step(1, 8'h9B, 0);
        step(1, 8'h9C, 0); check("sync_count_restart", 0, 0, 0, 8'h9D);
        step(1, 8'h9D, 0); check("relock_after_reseed", 1, 0, 0, 8'h9E);

        // Saturation on the 2-bit counter instance
        for (int d = 8'h10; d <= 8'h14; d++) begin
            s_valid = 1'b1; s_data = 8'(d);
            @(posedge CLK_I); #1;
        end
        n_tests++;
        if (s_locked !== 1'b1 || s_exp !== 8'h15) begin
            n_fail++;
            $display("FAIL sat_lock: got locked=%0b exp=%02h, want locked=1 exp=15", s_locked, s_exp);
        end
        for (int i = 0; i < 5; i++) begin
            logic [7:0] want_exp;
            want_exp = 8'(8'h16 + 2 * i);
            s_valid = 1'b1; s_data = 8'h00;
            @(posedge CLK_I); #1;
            n_tests++;
            if (s_err !== 1'b1 || s_cnt !== ((i < 3) ? 2'(i + 1) : 2'd3) || s_exp !== want_exp) begin
                n_fail++;
                $display("FAIL sat_err%0d: got err=%0b cnt=%0d exp=%02h, want err=1 cnt=%0d exp=%02h",
                         i, s_err, s_cnt, s_exp, (i < 3) ? i + 1 : 3, want_exp);
            end
            s_data = want_exp;
            @(posedge CLK_I); #1;
        end
        s_valid = 1'b0;
        n_tests++;
        if (s_locked !== 1'b1 || s_cnt !== 2'd3 || s_err !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_hold: got locked=%0b cnt=%0d err=%0b, want locked=1 cnt=3 err=0",
                     s_locked, s_cnt, s_err);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inc_seq_checker.md
Name: inc_seq_checker

Overview:
- Downstream consumer of the 8-bit incrementing data stage.
- Takes the registered byte stream, which is each input byte +1 mod 256, and checks that consecutive valid bytes increment by exactly 1.
- Acquires lock on the sequence and flywheels through isolated corrupt bytes.
- Reports per-byte error pulses, a saturating error count and lock status for status registers and bench scoreboards.

Parameters:
- P_LOCK_CNT, 4: consecutive matching bytes needed in SYNC to declare lock (1..15).
- P_UNLOCK_CNT, 3: consecutive mismatching bytes in LOCK that drop lock (1..15).
- P_ERR_W, 16: width of the error counter.

Ports:
- CLK_I  input  1  clock; the single clock domain.
- RST_X  input  1  reset; asynchronous, active-low.
- DATA_I  input  8  byte under check, synchronous to CLK_I.
- VALID_I  input  1  DATA_I qualifier; byte is sampled on a rising CLK_I edge with VALID_I=1.
- CLR_I  input  1  synchronous clear of ERR_CNT_O.
- LOCKED_O  output  1  high while in LOCK state.
- ERR_O  output  1  one-cycle pulse per mismatching byte sampled in LOCK.
- ERR_CNT_O  output  P_ERR_W  saturating count of ERR_O pulses.
- EXP_DATA_O  output  8  byte expected at the next valid sample.

Behaviour:
- Reset (RST_X=0, asynchronous):
  - State = HUNT; match_cnt and miss_cnt = 0.
  - LOCKED_O=0, ERR_O=0, ERR_CNT_O=0, EXP_DATA_O=8'h00.
  - Applies immediately, including mid-lock; after release, checking restarts from HUNT.
- All outputs are registered. A byte sampled at edge N affects outputs after edge N, so latency is 1 cycle.
- VALID_I=0 cycles:
  - No state, counter or EXP_DATA_O change.
  - ERR_O=0.
  - Gaps of any length are not errors.
- Match is defined as DATA_I == EXP_DATA_O.
- Wrap-around: 8'hFF followed by 8'h00 is a match. All expected-value arithmetic is 8-bit mod 256.
- HUNT:
  - On any valid byte: EXP_DATA_O <= DATA_I+1, match_cnt <= 0, go to SYNC.
  - No error is flagged in HUNT.
- SYNC, on a valid byte:
  - Match: match_cnt++ and EXP_DATA_O <= DATA_I+1. When match_cnt reaches P_LOCK_CNT, go to LOCK, set LOCKED_O=1 and miss_cnt <= 0.
  - Mismatch: match_cnt <= 0 and EXP_DATA_O <= DATA_I+1 (reseed). Stay in SYNC; no error flagged.
- LOCK, on a valid byte:
  - Match: miss_cnt <= 0 and EXP_DATA_O <= DATA_I+1.
  - Mismatch (flywheel):
    - ERR_O=1 for one cycle; ERR_CNT_O++ (saturates at all-ones).
    - EXP_DATA_O <= EXP_DATA_O+1, i.e. the corrupt byte is not used as the seed.
    - miss_cnt++.
    - When miss_cnt reaches P_UNLOCK_CNT: go to SYNC, LOCKED_O <= 0, match_cnt <= 0, EXP_DATA_O <= DATA_I+1 (reseed from that byte).
    - The unlocking byte itself still raises ERR_O.
- ERR_CNT_O saturation: the counter holds at 2^P_ERR_W-1; further errors still pulse ERR_O.
- CLR_I:
  - Alone: ERR_CNT_O <= 0.
  - Same edge as an error increment: ERR_CNT_O <= 1, so the new error is not lost.
  - No effect on state, LOCKED_O or EXP_DATA_O.
- Only HUNT, SYNC and LOCK are used. Any unused state encoding returns to HUNT on the next edge.

Test Plan:
- Reset values:
  - Assert RST_X=0 mid-stream → all outputs read 0 immediately.
  - Release and wait 5 idle cycles → still all 0, state HUNT.
- Acquire lock:
  - Valid bytes 8'h10,8'h11,8'h12,8'h13,8'h14 back-to-back → LOCKED_O rises the cycle after 8'h14 is sampled.
  - EXP_DATA_O=8'h15; ERR_CNT_O=0.
- Wrap-around and gaps:
  - While locked, send 8'hFE,8'hFF,(3 cycles VALID_I=0),8'h00,8'h01 → no ERR_O.
  - LOCKED_O stays 1; EXP_DATA_O=8'h02.
- Single glitch:
  - Locked stream 8'h20,8'h55,8'h22,8'h23 → exactly one ERR_O pulse (the cycle after 8'h55).
  - ERR_CNT_O=1; LOCKED_O stays 1.
- Loss of lock:
  - Locked at EXP=8'h30, send 8'h80,8'h81,8'h82 → three ERR_O pulses, ERR_CNT_O=3.
  - LOCKED_O falls after 8'h82; EXP_DATA_O=8'h83.
  - Then 8'h83..8'h86 → LOCKED_O re-rises after 8'h86.
- Clear collision and reset mid-lock:
  - With ERR_CNT_O=5, assert CLR_I on the same edge as a mismatch → ERR_CNT_O=1.
  - Then pulse RST_X low while locked → LOCKED_O=0 and ERR_CNT_O=0 asynchronously.
